// File: rtl/ttc_cmd_decoder.sv
// TTC command decoder: locks to the GBT link and turns command bytes into registered strobes.
// Optional event counters are built only when TTC_CMD_DECODER_COUNTERS_EN is defined.
module ttc_cmd_decoder #(
   parameter logic [7:0] CMD_L1A      = 8'h01,
   parameter logic [7:0] CMD_BC0      = 8'h02,
   parameter logic [7:0] CMD_RESYNC   = 8'h04,
   parameter logic [7:0] CMD_CALPULSE = 8'h08,
   parameter int         LOCK_CYCLES  = 16,
   parameter int         RESYNC_HOLD  = 8,
   parameter int         L1A_MIN_GAP  = 3
) (
   input  logic        clock,
   input  logic        reset,
   input  logic        link_ready,
   input  logic [7:0]  ttc_cmd,
   output logic        ttc_l1a,
   output logic        ttc_bc0,
   output logic        ttc_resync,
   output logic        ttc_calpulse,
   output logic        cmd_err,
   output logic        l1a_rule_err,
   output logic        locked,
   output logic [15:0] l1a_cnt,
   output logic [15:0] bc0_cnt,
   output logic [15:0] resync_cnt,
   output logic [15:0] err_cnt,
   output logic [1:0]  dbg_state
);

   localparam logic [7:0] LOCK_LAST = 8'(LOCK_CYCLES - 1);
   localparam logic [7:0] HOLD_INIT = 8'(RESYNC_HOLD);
   localparam logic [3:0] GAP_SAT   = 4'(L1A_MIN_GAP);

   typedef enum logic [1:0] {
      ST_UNLOCKED = 2'd0,
      ST_LOCKED   = 2'd1,
      ST_HOLD     = 2'd2
   } state_t;

   state_t     state, state_d;
   logic [7:0] lock_cnt, lock_cnt_d;
   logic [7:0] hold_cnt, hold_cnt_d;
   logic [3:0] gap_cnt, gap_cnt_d;

   logic is_l1a, is_bc0, is_resync, is_cal, is_unknown, l1a_accept;

   // State register
   always_ff @(posedge clock or negedge reset) begin
      if (!reset) begin
         state    <= ST_UNLOCKED;
         lock_cnt <= 8'd0;
         hold_cnt <= 8'd0;
         gap_cnt  <= 4'd0;
      end else begin
         state    <= state_d;
         lock_cnt <= lock_cnt_d;
         hold_cnt <= hold_cnt_d;
         gap_cnt  <= gap_cnt_d;
      end
   end

   // Next-state logic. The gap timer keeps counting in HOLD; only accepted L1As restart it.
   always_comb begin
      state_d    = state;
      lock_cnt_d = lock_cnt;
      hold_cnt_d = hold_cnt;
      gap_cnt_d  = (gap_cnt == GAP_SAT) ? gap_cnt : gap_cnt + 4'd1;
      case (state)
         ST_UNLOCKED: begin
            if (!link_ready) begin
               lock_cnt_d = 8'd0;
            end else if (lock_cnt == LOCK_LAST) begin
               state_d    = ST_LOCKED;
               lock_cnt_d = 8'd0;
               gap_cnt_d  = GAP_SAT;
            end else begin
               lock_cnt_d = lock_cnt + 8'd1;
            end
         end
         ST_LOCKED: begin
            if (!link_ready) begin
               state_d = ST_UNLOCKED;
            end else if (is_resync) begin
               state_d    = ST_HOLD;
               hold_cnt_d = HOLD_INIT;
            end
            if (l1a_accept) gap_cnt_d = 4'd1;
         end
         ST_HOLD: begin
            if (!link_ready) begin
               state_d    = ST_UNLOCKED;
               hold_cnt_d = 8'd0;
            end else if (is_resync) begin
               hold_cnt_d = HOLD_INIT;
            end else if (hold_cnt <= 8'd1) begin
               state_d    = ST_LOCKED;
               hold_cnt_d = 8'd0;
               gap_cnt_d  = GAP_SAT;
            end else begin
               hold_cnt_d = hold_cnt - 8'd1;
            end
         end
         default: begin
            state_d    = ST_UNLOCKED;
            lock_cnt_d = 8'd0;
            hold_cnt_d = 8'd0;
         end
      endcase
   end

   // Output decode: commands are ignored while unlocked or while the link is dropping.
   always_comb begin
      is_l1a     = 1'b0;
      is_bc0     = 1'b0;
      is_resync  = 1'b0;
      is_cal     = 1'b0;
      is_unknown = 1'b0;
      if (state != ST_UNLOCKED && link_ready) begin
         if (ttc_cmd == CMD_L1A)           is_l1a     = 1'b1;
         else if (ttc_cmd == CMD_BC0)      is_bc0     = 1'b1;
         else if (ttc_cmd == CMD_RESYNC)   is_resync  = 1'b1;
         else if (ttc_cmd == CMD_CALPULSE) is_cal     = 1'b1;
         else if (ttc_cmd != 8'h00)        is_unknown = 1'b1;
      end
      l1a_accept = is_l1a && (state == ST_LOCKED) && (gap_cnt == GAP_SAT);
   end

   always_ff @(posedge clock or negedge reset) begin
      if (!reset) begin
         ttc_l1a      <= 1'b0;
         ttc_bc0      <= 1'b0;
         ttc_resync   <= 1'b0;
         ttc_calpulse <= 1'b0;
         cmd_err      <= 1'b0;
         l1a_rule_err <= 1'b0;
      end else begin
         ttc_l1a      <= l1a_accept;
         ttc_bc0      <= is_bc0;
         ttc_resync   <= is_resync;
         ttc_calpulse <= is_cal;
         cmd_err      <= is_unknown;
         l1a_rule_err <= is_l1a && !l1a_accept;
      end
   end

   assign locked    = (state == ST_LOCKED);
   assign dbg_state = state;

`ifdef TTC_CMD_DECODER_COUNTERS_EN
   logic [15:0] l1a_cnt_q, bc0_cnt_q, resync_cnt_q, err_cnt_q;

   function automatic logic [15:0] sat_inc(input logic [15:0] v);
      return (v == 16'hFFFF) ? v : v + 16'd1;
   endfunction

   // Counters follow the emitted strobes; resync clears all but its own count.
   always_ff @(posedge clock or negedge reset) begin
      if (!reset) begin
         l1a_cnt_q    <= 16'd0;
         bc0_cnt_q    <= 16'd0;
         resync_cnt_q <= 16'd0;
         err_cnt_q    <= 16'd0;
      end else if (ttc_resync) begin
         l1a_cnt_q    <= 16'd0;
         bc0_cnt_q    <= 16'd0;
         err_cnt_q    <= 16'd0;
         resync_cnt_q <= sat_inc(resync_cnt_q);
      end else begin
         if (ttc_l1a)                 l1a_cnt_q <= sat_inc(l1a_cnt_q);
         if (ttc_bc0)                 bc0_cnt_q <= sat_inc(bc0_cnt_q);
         if (cmd_err || l1a_rule_err) err_cnt_q <= sat_inc(err_cnt_q);
      end
   end

   assign l1a_cnt    = l1a_cnt_q;
   assign bc0_cnt    = bc0_cnt_q;
   assign resync_cnt = resync_cnt_q;
   assign err_cnt    = err_cnt_q;
`else
   assign l1a_cnt    = 16'h0000;
   assign bc0_cnt    = 16'h0000;
   assign resync_cnt = 16'h0000;
   assign err_cnt    = 16'h0000;
`endif

endmodule
